// File: rtl/winograd_output_transform_acc.sv
`default_nettype none
// ============================================================================
// Module   : winograd_output_transform_acc
// Brief    : Winograd F(2x2,3x3) output stage: accumulates per-channel 4x4
//            product tiles, applies Y = A^T*M*A, optional ReLU, saturation.
// Revision : 1.0 - initial release
// ============================================================================
module winograd_output_transform_acc #(
    parameter int W      = 16,
    parameter int AW     = W + 8,
    parameter int OW     = 16,
    parameter int CH_MAX = 256,
    parameter int CW     = $clog2(CH_MAX + 1)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              clear,
    input  logic [CW-1:0]     cfg_nch,
    input  logic              relu_en,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [16*W-1:0]   in_m,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [4*OW-1:0]   out_y,
    output logic              out_sat
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ACC  = 3'd1,
        S_XF1  = 3'd2,
        S_XF2  = 3'd3,
        S_OUT  = 3'd4
    } state_t;

    localparam logic [CW-1:0]           c_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic signed [AW+3:0]    c_YMAX = {{(AW+5-OW){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [AW+3:0]    c_YMIN = {{(AW+5-OW){1'b1}}, {(OW-1){1'b0}}};
    localparam logic [OW-1:0]           c_OMAX = {1'b0, {(OW-1){1'b1}}};
    localparam logic [OW-1:0]           c_OMIN = {1'b1, {(OW-1){1'b0}}};

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   r_alive;

    // Input stage register: an accepted beat is folded into acc one edge later.
    logic [16*W-1:0]        r_m;
    logic                   r_m_vld;
    logic                   r_m_first;
    logic                   r_m_last;

    logic [CW-1:0]          r_cnt;
    logic [CW-1:0]          r_nch;
    logic                   r_relu;

    logic signed [AW-1:0]   r_acc     [16];
    logic signed [AW-1:0]   w_m_ext   [16];
    logic signed [AW-1:0]   w_acc_nxt [16];
    logic signed [AW+1:0]   w_t       [8];
    logic signed [AW+1:0]   r_t       [8];
    logic signed [AW+3:0]   w_yr      [4];
    logic signed [AW+3:0]   w_yl      [4];
    logic [OW-1:0]          w_yc      [4];
    logic [3:0]             w_clip;

    logic [4*OW-1:0]        r_out_y;
    logic                   r_out_valid;
    logic                   r_out_sat;

    logic                   w_pend_last;
    logic                   w_accept;
    logic [CW-1:0]          w_nch_in;

    function automatic logic signed [AW+1:0] sx2(input logic signed [AW-1:0] a);
        return {{2{a[AW-1]}}, a};
    endfunction

    function automatic logic signed [AW+3:0] sx4(input logic signed [AW+1:0] a);
        return {{2{a[AW+1]}}, a};
    endfunction

    assign w_pend_last = r_m_vld && r_m_last;
    assign in_ready    = r_alive && ((r_state == S_IDLE) ||
                                     ((r_state == S_ACC) && !w_pend_last));
    assign w_accept    = in_valid && in_ready && !clear;
    assign w_nch_in    = (cfg_nch == '0) ? c_ONE : cfg_nch;

    assign out_y     = r_out_y;
    assign out_valid = r_out_valid;
    assign out_sat   = r_out_sat;

    // ------------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept)    w_state_nxt = S_ACC;
            S_ACC:   if (w_pend_last) w_state_nxt = S_XF1;
            S_XF1:                    w_state_nxt = S_XF2;
            S_XF2:                    w_state_nxt = S_OUT;
            S_OUT:   if (out_ready)   w_state_nxt = S_IDLE;
            default:                  w_state_nxt = S_IDLE;
        endcase
        if (clear) begin
            w_state_nxt = S_IDLE;
        end
    end

    // ------------------------------------------------------------------------
    // Combinational datapath
    // ------------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            w_m_ext[i]   = {{(AW-W){r_m[i*W+W-1]}}, r_m[i*W +: W]};
            w_acc_nxt[i] = r_m_first ? w_m_ext[i] : (r_acc[i] + w_m_ext[i]);
        end
    end

    always_comb begin
        for (int c = 0; c < 4; c++) begin
            w_t[c]   = sx2(r_acc[c])   + sx2(r_acc[4+c]) + sx2(r_acc[8+c]);
            w_t[4+c] = sx2(r_acc[4+c]) - sx2(r_acc[8+c]) - sx2(r_acc[12+c]);
        end
    end

    always_comb begin
        w_yr[0] = sx4(r_t[0]) + sx4(r_t[1]) + sx4(r_t[2]);
        w_yr[1] = sx4(r_t[1]) - sx4(r_t[2]) - sx4(r_t[3]);
        w_yr[2] = sx4(r_t[4]) + sx4(r_t[5]) + sx4(r_t[6]);
        w_yr[3] = sx4(r_t[5]) - sx4(r_t[6]) - sx4(r_t[7]);
        for (int k = 0; k < 4; k++) begin
            w_yl[k]   = (r_relu && w_yr[k][AW+3]) ? '0 : w_yr[k];
            w_clip[k] = 1'b0;
            if (w_yl[k] > c_YMAX) begin
                w_yc[k]   = c_OMAX;
                w_clip[k] = 1'b1;
            end else if (w_yl[k] < c_YMIN) begin
                w_yc[k]   = c_OMIN;
                w_clip[k] = 1'b1;
            end else begin
                w_yc[k]   = w_yl[k][OW-1:0];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Sequential datapath
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_alive     <= 1'b0;
            r_m         <= '0;
            r_m_vld     <= 1'b0;
            r_m_first   <= 1'b0;
            r_m_last    <= 1'b0;
            r_cnt       <= '0;
            r_nch       <= '0;
            r_relu      <= 1'b0;
            r_out_y     <= '0;
            r_out_valid <= 1'b0;
            r_out_sat   <= 1'b0;
            for (int i = 0; i < 16; i++) r_acc[i] <= '0;
            for (int i = 0; i < 8; i++)  r_t[i]   <= '0;
        end else if (clear) begin
            r_alive     <= 1'b1;
            r_m_vld     <= 1'b0;
            r_m_first   <= 1'b0;
            r_m_last    <= 1'b0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_out_sat   <= 1'b0;
            for (int i = 0; i < 16; i++) r_acc[i] <= '0;
        end else begin
            r_alive <= 1'b1;
            r_m_vld <= w_accept;

            if (w_accept) begin
                r_m <= in_m;
                if (r_state == S_IDLE) begin
                    // Tile configuration is frozen on the first beat.
                    r_nch     <= w_nch_in;
                    r_relu    <= relu_en;
                    r_cnt     <= c_ONE;
                    r_m_first <= 1'b1;
                    r_m_last  <= (w_nch_in == c_ONE);
                end else begin
                    r_cnt     <= r_cnt + c_ONE;
                    r_m_first <= 1'b0;
                    r_m_last  <= ((r_cnt + c_ONE) == r_nch);
                end
            end

            if (r_m_vld) begin
                for (int i = 0; i < 16; i++) r_acc[i] <= w_acc_nxt[i];
            end

            if (r_state == S_XF1) begin
                for (int i = 0; i < 8; i++) r_t[i] <= w_t[i];
            end

            if (r_state == S_XF2) begin
                for (int k = 0; k < 4; k++) r_out_y[k*OW +: OW] <= w_yc[k];
                r_out_sat   <= |w_clip;
                r_out_valid <= 1'b1;
            end else if ((r_state == S_OUT) && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire
